// File: rtl/mem_responder.sv
// Memory-side responder for the MFA/MFC four-phase handshake: captures a request,
// waits LATENCY edges, then does a big-endian byte/half/word access on a byte RAM.
module mem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MFA,
    input  logic        MOP,
    input  logic [1:0]  SIZE,
    input  logic        SGN,
    input  logic [31:0] ADDR,
    input  logic [31:0] DATA_IN,
    output logic [31:0] DATA_OUT,
    output logic        MFC,
    output logic        ALIGN_ERR
);
    localparam int         DEPTH    = 2 ** ADDR_BITS;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, RELEASE} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic                  rd;
    logic                  sgn;
    logic [1:0]            size;
    logic [ADDR_BITS-1:0]  addr;
    logic [31:0]           wdata;
    logic [7:0]            ram [DEPTH];

    logic [ADDR_BITS-1:0]  a1, a2, a3;
    logic                  is_half, is_word, misaligned, fire;
    logic [31:0]           rdata;
    logic                  unused_addr;

    // Address bits above the RAM depth are ignored, so accesses wrap.
    assign unused_addr = ^ADDR[31:ADDR_BITS];

    assign a1         = addr + ADDR_BITS'(1);
    assign a2         = addr + ADDR_BITS'(2);
    assign a3         = addr + ADDR_BITS'(3);
    assign is_word    = size[1];
    assign is_half    = (size == 2'b01);
    assign misaligned = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
    assign fire       = (state == BUSY) && (cnt == 4'd0);

    always_comb begin
        rdata = '0;
        if (is_word)
            rdata = {ram[addr], ram[a1], ram[a2], ram[a3]};
        else if (is_half)
            rdata = {{16{sgn & ram[addr][7]}}, ram[addr], ram[a1]};
        else
            rdata = {{24{sgn & ram[addr][7]}}, ram[addr]};
    end

    // RAM is never reset; all bytes of one access land on the completing edge.
    always_ff @(posedge Clk) begin
        if (fire && !rd && !misaligned) begin
            if (is_word) begin
                ram[addr] <= wdata[31:24];
                ram[a1]   <= wdata[23:16];
                ram[a2]   <= wdata[15:8];
                ram[a3]   <= wdata[7:0];
            end else if (is_half) begin
                ram[addr] <= wdata[15:8];
                ram[a1]   <= wdata[7:0];
            end else begin
                ram[addr] <= wdata[7:0];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rd        <= 1'b0;
            sgn       <= 1'b0;
            size      <= 2'b00;
            addr      <= '0;
            wdata     <= '0;
            DATA_OUT  <= '0;
            MFC       <= 1'b0;
            ALIGN_ERR <= 1'b0;
        end else begin
            case (state)
                IDLE: if (MFA) begin
                    rd    <= MOP;
                    size  <= SIZE;
                    sgn   <= SGN;
                    addr  <= ADDR[ADDR_BITS-1:0];
                    wdata <= DATA_IN;
                    cnt   <= CNT_INIT;
                    state <= BUSY;
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        MFC       <= 1'b1;
                        ALIGN_ERR <= misaligned;
                        if (rd && !misaligned)
                            DATA_OUT <= rdata;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: if (!MFA) begin
                    MFC       <= 1'b0;
                    ALIGN_ERR <= 1'b0;
                    state     <= RELEASE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus random traffic
// compared against a byte-array model of the big-endian memory.
module tb_mem_responder;
    localparam int LAT = 2;

    logic        Clk = 1'b0;
    logic        Reset, MFA, MOP, SGN;
    logic [1:0]  SIZE;
    logic [31:0] ADDR, DATA_IN;
    logic [31:0] DATA_OUT;
    logic        MFC, ALIGN_ERR;

    int checks = 0, passes = 0, fails = 0;
    byte unsigned mem [256];
    logic [31:0]  exp_dout;

    mem_responder #(.ADDR_BITS(8), .LATENCY(LAT)) dut (
        .Clk(Clk), .Reset(Reset), .MFA(MFA), .MOP(MOP), .SIZE(SIZE), .SGN(SGN),
        .ADDR(ADDR), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .MFC(MFC),
        .ALIGN_ERR(ALIGN_ERR)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Memory as plain bytes: size in bytes, alignment by modulo, value by base-256 arithmetic.
    function automatic bit model(input bit rd, input bit [1:0] sz, input bit sg,
                                 input bit [31:0] a, input bit [31:0] d);
        int n, base;
        longint v;
        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base = int'(a % 256);
        if (base % n != 0) return 1'b1;
        if (rd) begin
            v = 0;
            for (int k = 0; k < n; k++) v = v * 256 + mem[(base + k) % 256];
            if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
            exp_dout = v[31:0];
        end else begin
            for (int k = 0; k < n; k++) mem[(base + k) % 256] = byte'((d >> (8 * (n - 1 - k))) & 32'hFF);
        end
        return 1'b0;
    endfunction

    task automatic drive(input bit rd, input bit [1:0] sz, input bit sg,
                         input bit [31:0] a, input bit [31:0] d);
        MFA = 1'b1; MOP = rd; SIZE = sz; SGN = sg; ADDR = a; DATA_IN = d;
    endtask

    task automatic wait_mfc(output int lat);
        lat = 0;
        do begin
            @(negedge Clk);
            lat++;
        end while (!MFC && lat < 40);
    endtask

    // Entered and left on a negedge, with the DUT idle.
    task automatic xact(input bit rd, input bit [1:0] sz, input bit sg,
                        input bit [31:0] a, input bit [31:0] d, input string tag);
        bit e;
        int lat;
        e = model(rd, sz, sg, a, d);
        drive(rd, sz, sg, a, d);
        wait_mfc(lat);
        check({tag, ".lat"}, lat, LAT + 1);
        check({tag, ".dout"}, DATA_OUT, exp_dout);
        check({tag, ".aerr"}, {31'd0, ALIGN_ERR}, {31'd0, e});
        MFA = 1'b0;
        @(negedge Clk);
        check({tag, ".mfc_rel"}, {31'd0, MFC}, 32'd0);
        @(negedge Clk);
    endtask

    initial begin
        int lat;
        bit e;
        logic [31:0] x1, x2;
        Reset = 1'b0; MFA = 1'b0; MOP = 1'b0; SIZE = 2'b00; SGN = 1'b0;
        ADDR = '0; DATA_IN = '0; exp_dout = '0;
        #1;
        check("rst.mfc", {31'd0, MFC}, 32'd0);
        check("rst.aerr", {31'd0, ALIGN_ERR}, 32'd0);
        check("rst.dout", DATA_OUT, 32'd0);
        @(negedge Clk); @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);

        // Fill the whole RAM through the port so the model knows every byte.
        for (int i = 0; i < 64; i++) xact(1'b0, 2'd2, 1'b0, 32'(i * 4), $urandom, "preload");

        xact(1'b0, 2'd2, 1'b0, 32'h0, 32'h9C044012, "t1.wr");
        xact(1'b1, 2'd2, 1'b0, 32'h0, 32'h0, "t1.rd");
        check("t1.value", exp_dout, 32'h9C044012);

        xact(1'b0, 2'd2, 1'b0, 32'h8, 32'hA2044012, "t2.wr");
        xact(1'b1, 2'd0, 1'b0, 32'h9, 32'h0, "t2.b9");
        check("t2.b9.value", DATA_OUT, 32'h00000004);
        xact(1'b1, 2'd0, 1'b1, 32'h8, 32'h0, "t2.b8s");
        check("t2.b8s.value", DATA_OUT, 32'hFFFFFFA2);
        xact(1'b1, 2'd1, 1'b1, 32'hA, 32'h0, "t2.h10s");
        check("t2.h10s.value", DATA_OUT, 32'h00004012);

        xact(1'b1, 2'd1, 1'b0, 32'h3, 32'h0, "t3.hrd3");
        xact(1'b0, 2'd2, 1'b0, 32'h6, 32'hDEADBEEF, "t3.wwr6");
        xact(1'b1, 2'd2, 1'b0, 32'h4, 32'h0, "t3.rd4");
        xact(1'b1, 2'd2, 1'b0, 32'h8, 32'h0, "t3.rd8");

        // Hold MFA after MFC while the inputs change: nothing new may be captured.
        x1 = $urandom; x2 = ~x1;
        e = model(1'b0, 2'd2, 1'b0, 32'h20, x1);
        drive(1'b0, 2'd2, 1'b0, 32'h20, x1);
        wait_mfc(lat);
        check("t4.lat", lat, LAT + 1);
        ADDR = 32'h24; DATA_IN = x2;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            check("t4.hold_mfc", {31'd0, MFC}, 32'd1);
        end
        MFA = 1'b0;
        @(negedge Clk);
        check("t4.rel_mfc", {31'd0, MFC}, 32'd0);
        e = model(1'b1, 2'd2, 1'b0, 32'h20, 32'h0);
        drive(1'b1, 2'd2, 1'b0, 32'h20, 32'h0);
        wait_mfc(lat);
        check("t4.rereq_lat", lat, LAT + 2);
        check("t4.rereq_dout", DATA_OUT, x1);
        MFA = 1'b0;
        @(negedge Clk); @(negedge Clk);
        xact(1'b1, 2'd2, 1'b0, 32'h24, 32'h0, "t4.rd24");

        xact(1'b0, 2'd2, 1'b0, 32'h1FE, 32'h11223344, "t6.w1fe");
        xact(1'b0, 2'd2, 1'b0, 32'h1FC, 32'h55667788, "t6.w1fc");
        xact(1'b1, 2'd0, 1'b0, 32'hFC, 32'h0, "t6.bfc");
        xact(1'b1, 2'd0, 1'b0, 32'hFF, 32'h0, "t6.bff");
        check("t6.bff.value", DATA_OUT, 32'h00000088);
        xact(1'b0, 2'd1, 1'b0, 32'hFF, 32'hAAAA, "t6.hff");
        xact(1'b1, 2'd2, 1'b0, 32'hFC, 32'h0, "t6.rdfc");

        // MFA dropped while busy: the write still lands, MFC is a one-cycle pulse.
        x1 = $urandom;
        e = model(1'b0, 2'd2, 1'b0, 32'h40, x1);
        drive(1'b0, 2'd2, 1'b0, 32'h40, x1);
        @(negedge Clk);
        MFA = 1'b0;
        @(negedge Clk);
        check("viol.mfc_lo", {31'd0, MFC}, 32'd0);
        @(negedge Clk);
        check("viol.mfc_hi", {31'd0, MFC}, 32'd1);
        @(negedge Clk);
        check("viol.mfc_pulse", {31'd0, MFC}, 32'd0);
        @(negedge Clk);
        xact(1'b1, 2'd2, 1'b0, 32'h40, 32'h0, "viol.rd");

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 a, $urandom, "rand");
        end

        // Reset in the middle of a busy word write aborts it without touching RAM.
        xact(1'b1, 2'd2, 1'b0, 32'h0, 32'h0, "t5.pre");
        drive(1'b0, 2'd2, 1'b0, 32'h10, $urandom);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        check("t5.mfc", {31'd0, MFC}, 32'd0);
        check("t5.dout", DATA_OUT, 32'd0);
        check("t5.aerr", {31'd0, ALIGN_ERR}, 32'd0);
        exp_dout = 32'd0;
        MFA = 1'b0;
        @(negedge Clk); @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        xact(1'b1, 2'd2, 1'b0, 32'h10, 32'h0, "t5.rd16");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
